// File: rtl/multi_sync_filter.sv
// Multi-channel asynchronous-level synchroniser for the clk domain: per-channel
// N-flop chain, optional stability filter and registered edge pulses.
module multi_sync_filter #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      STAGES    = 3,
    parameter int unsigned      FILTER    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int unsigned     CW      = (FILTER == 0) ? 1 : $clog2(FILTER + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(FILTER);

    if (STAGES < 2) begin : g_stages_check
        $error("multi_sync_filter: STAGES must be >= 2");
    end

    logic [STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]             tap;
    logic [WIDTH-1:0][CW-1:0]     cnt;
    logic [WIDTH-1:0][CW-1:0]     cnt_nxt;
    logic [WIDTH-1:0]             upd;

    assign tap = chain[STAGES-1];

    // A channel updates only after its tap has disagreed with sync_out on
    // FILTER+1 consecutive edges; any agreement clears the count.
    always_comb begin
        upd     = '0;
        cnt_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (tap[i] != sync_out[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    upd[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain      <= {STAGES{RESET_VAL}};
            sync_out   <= RESET_VAL;
            cnt        <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            chain[0] <= async_in;
            for (int unsigned k = 1; k < STAGES; k++) begin
                chain[k] <= chain[k-1];
            end
            cnt        <= cnt_nxt;
            sync_out   <= (sync_out & ~upd) | (tap & upd);
            rise_pulse <= upd & tap;
            fall_pulse <= upd & ~tap;
            any_change <= |upd;
        end
    end

endmodule

// File: tb/tb_multi_sync_filter.sv
// Scoreboard bench for multi_sync_filter: five parameter variants, expected
// output events queued by the stimulus and matched by a negedge monitor.
module tb_multi_sync_filter;

    localparam int NDUT = 5;

    typedef struct {
        int       dut;
        int       cyc;
        logic [3:0] so;
        logic [3:0] rp;
        logic [3:0] fp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] ain [NDUT];
    logic [3:0] so  [NDUT];
    logic [3:0] rp  [NDUT];
    logic [3:0] fp  [NDUT];
    logic       ac  [NDUT];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // d0: S3 F0, d1: S3 F3, d2: S3 F0 RESET_VAL=1010, d3: S2 F0, d4: S4 F0
    multi_sync_filter #(.WIDTH(4), .STAGES(3), .FILTER(0), .RESET_VAL(4'b0000)) d0 (
        .clk(clk), .reset_n(reset_n), .async_in(ain[0]), .sync_out(so[0]),
        .rise_pulse(rp[0]), .fall_pulse(fp[0]), .any_change(ac[0]));
    multi_sync_filter #(.WIDTH(4), .STAGES(3), .FILTER(3), .RESET_VAL(4'b0000)) d1 (
        .clk(clk), .reset_n(reset_n), .async_in(ain[1]), .sync_out(so[1]),
        .rise_pulse(rp[1]), .fall_pulse(fp[1]), .any_change(ac[1]));
    multi_sync_filter #(.WIDTH(4), .STAGES(3), .FILTER(0), .RESET_VAL(4'b1010)) d2 (
        .clk(clk), .reset_n(reset_n), .async_in(ain[2]), .sync_out(so[2]),
        .rise_pulse(rp[2]), .fall_pulse(fp[2]), .any_change(ac[2]));
    multi_sync_filter #(.WIDTH(4), .STAGES(2), .FILTER(0), .RESET_VAL(4'b0000)) d3 (
        .clk(clk), .reset_n(reset_n), .async_in(ain[3]), .sync_out(so[3]),
        .rise_pulse(rp[3]), .fall_pulse(fp[3]), .any_change(ac[3]));
    multi_sync_filter #(.WIDTH(4), .STAGES(4), .FILTER(0), .RESET_VAL(4'b0000)) d4 (
        .clk(clk), .reset_n(reset_n), .async_in(ain[4]), .sync_out(so[4]),
        .rise_pulse(rp[4]), .fall_pulse(fp[4]), .any_change(ac[4]));

    task automatic expect_ev(input int d, input int c, input logic [3:0] s,
                             input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.dut = d; e.cyc = c; e.so = s; e.rp = r; e.fp = f;
        sb.push_back(e);
    endtask

    task automatic check_state(input string name, input int d, input logic [3:0] s);
        checks++;
        if (so[d] !== s || rp[d] !== 4'b0 || fp[d] !== 4'b0 || ac[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d: got so=%b rp=%b fp=%b ac=%b, want so=%b rp=0000 fp=0000 ac=0",
                     name, d, so[d], rp[d], fp[d], ac[d], s);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse cycle must match the oldest queued event of that DUT.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (ac[d] !== |(rp[d] | fp[d]) || (rp[d] & fp[d]) !== 4'b0) begin
                    errors++;
                    $display("FAIL pulse_consistency dut%0d cyc%0d: got ac=%b rp=%b fp=%b, want ac=|(rp|fp), rp&fp=0",
                             d, cyc, ac[d], rp[d], fp[d]);
                end
                if (ac[d] === 1'b1) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].dut == d) idx = i;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_event dut%0d cyc%0d: got so=%b rp=%b fp=%b, want no pulse",
                                 d, cyc, so[d], rp[d], fp[d]);
                    end else begin
                        if (sb[idx].cyc != cyc || sb[idx].so !== so[d] ||
                            sb[idx].rp !== rp[d] || sb[idx].fp !== fp[d]) begin
                            errors++;
                            $display("FAIL event dut%0d: got cyc=%0d so=%b rp=%b fp=%b, want cyc=%0d so=%b rp=%b fp=%b",
                                     d, cyc, so[d], rp[d], fp[d],
                                     sb[idx].cyc, sb[idx].so, sb[idx].rp, sb[idx].fp);
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0;
        for (int d = 0; d < NDUT; d++) ain[d] = 4'b0000;
        ain[2] = 4'b1010;

        step(3);
        check_state("reset_d0", 0, 4'b0000);
        check_state("reset_d1", 1, 4'b0000);
        check_state("reset_d2", 2, 4'b1010);
        check_state("reset_d3", 3, 4'b0000);
        check_state("reset_d4", 4, 4'b0000);
        reset_n = 1'b1;
        step(3);

        // Basic latency for STAGES = 3, 2, 4 (FILTER=0): edges 4, 3, 5.
        n = cyc;
        ain[0] = 4'b0001; expect_ev(0, n + 4, 4'b0001, 4'b0001, 4'b0000);
        ain[3] = 4'b0001; expect_ev(3, n + 3, 4'b0001, 4'b0001, 4'b0000);
        ain[4] = 4'b0001; expect_ev(4, n + 5, 4'b0001, 4'b0001, 4'b0000);
        step(10);
        n = cyc;
        ain[0] = 4'b0000; expect_ev(0, n + 4, 4'b0000, 4'b0000, 4'b0001);
        ain[3] = 4'b0000; expect_ev(3, n + 3, 4'b0000, 4'b0000, 4'b0001);
        ain[4] = 4'b0000; expect_ev(4, n + 5, 4'b0000, 4'b0000, 4'b0001);
        step(10);

        // FILTER=3: a 3-cycle excursion is dropped, a 6-cycle one passes.
        ain[1] = 4'b0010; step(3); ain[1] = 4'b0000;
        step(12);
        n = cyc;
        ain[1] = 4'b0010; expect_ev(1, n + 7, 4'b0010, 4'b0010, 4'b0000);
        step(6);
        ain[1] = 4'b0000; expect_ev(1, n + 13, 4'b0000, 4'b0000, 4'b0010);
        step(12);
        check_state("filter_idle_d1", 1, 4'b0000);

        // Simultaneous then staggered toggles on all four channels.
        n = cyc;
        ain[0] = 4'b1111; expect_ev(0, n + 4, 4'b1111, 4'b1111, 4'b0000);
        step(8);
        n = cyc;
        ain[0] = 4'b0000; expect_ev(0, n + 4, 4'b0000, 4'b0000, 4'b1111);
        step(8);
        n = cyc;
        expect_ev(0, n + 4, 4'b0001, 4'b0001, 4'b0000);
        expect_ev(0, n + 5, 4'b0011, 4'b0010, 4'b0000);
        expect_ev(0, n + 6, 4'b0111, 4'b0100, 4'b0000);
        expect_ev(0, n + 7, 4'b1111, 4'b1000, 4'b0000);
        ain[0] = 4'b0001; step(1);
        ain[0] = 4'b0011; step(1);
        ain[0] = 4'b0111; step(1);
        ain[0] = 4'b1111;
        step(8);
        check_state("stagger_hold_d0", 0, 4'b1111);

        // Reset mid-filter-count (d1 cnt=2), asserted between clock edges.
        n = cyc;
        ain[1] = 4'b0001;
        step(5);
        #2 reset_n = 1'b0;
        #1;
        check_state("async_reset_d0", 0, 4'b0000);
        check_state("async_reset_d1", 1, 4'b0000);
        check_state("async_reset_d2", 2, 4'b1010);
        step(2);
        n = cyc;
        reset_n = 1'b1;
        expect_ev(0, n + 4, 4'b1111, 4'b1111, 4'b0000);
        expect_ev(1, n + 7, 4'b0001, 4'b0001, 4'b0000);
        step(22);

        // RESET_VAL=1010 held through release: quiet so far, then fall on 1010.
        check_state("resetval_quiet_d2", 2, 4'b1010);
        n = cyc;
        ain[2] = 4'b0000; expect_ev(2, n + 4, 4'b0000, 4'b0000, 4'b1010);
        step(12);

        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_event dut%0d: got no pulse, want cyc=%0d so=%b rp=%b fp=%b",
                     sb[0].dut, sb[0].cyc, sb[0].so, sb[0].rp, sb[0].fp);
            void'(sb.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
